// File: rtl/dmem_port_arbiter_if.sv
// Port-B bus between the data-port arbiter, its two requesters and the memory.
// master = requesters plus memory read-data side; slave = the arbiter.
interface dmem_port_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;

    logic                  r0_valid;
    logic                  r0_ready;
    logic [ADDR_WIDTH-1:0] r0_addr;
    logic                  r0_we;
    logic [DATA_WIDTH-1:0] r0_wdata;
    logic [BE_WIDTH-1:0]   r0_be;
    logic                  r0_rvalid;
    logic [DATA_WIDTH-1:0] r0_rdata;

    logic                  r1_valid;
    logic                  r1_ready;
    logic [ADDR_WIDTH-1:0] r1_addr;
    logic                  r1_we;
    logic [DATA_WIDTH-1:0] r1_wdata;
    logic [BE_WIDTH-1:0]   r1_be;
    logic                  r1_rvalid;
    logic [DATA_WIDTH-1:0] r1_rdata;

    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_wr_en;
    logic [DATA_WIDTH-1:0] mem_wr_data;
    logic [BE_WIDTH-1:0]   mem_byte_en;
    logic [DATA_WIDTH-1:0] mem_rd_data;

    modport master (
        output r0_valid, r0_addr, r0_we, r0_wdata, r0_be,
        output r1_valid, r1_addr, r1_we, r1_wdata, r1_be,
        output mem_rd_data,
        input  r0_ready, r0_rvalid, r0_rdata,
        input  r1_ready, r1_rvalid, r1_rdata,
        input  mem_addr, mem_wr_en, mem_wr_data, mem_byte_en
    );

    modport slave (
        input  r0_valid, r0_addr, r0_we, r0_wdata, r0_be,
        input  r1_valid, r1_addr, r1_we, r1_wdata, r1_be,
        input  mem_rd_data,
        output r0_ready, r0_rvalid, r0_rdata,
        output r1_ready, r1_rvalid, r1_rdata,
        output mem_addr, mem_wr_en, mem_wr_data, mem_byte_en
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Round-robin (bounded burst) arbiter sharing memory port B between LSU (r0) and debug loader (r1).
// Grant is combinational (0-cycle accept); load data returns exactly 1 cycle later, no back-pressure.
module dmem_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 4
) (
    input logic clk,
    input logic rst,
    dmem_port_arbiter_if.slave bus
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;
    localparam int CNT_W    = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             last_gnt;
    logic [CNT_W-1:0] burst_cnt;
    logic             pend_valid;
    logic             pend_id;

    logic gnt_vld;
    logic gnt_id;
    logic gnt_we;
    logic burst_full;

    assign burst_full = (burst_cnt == CNT_MAX);

    // Nothing is granted while reset is held, so no store can slip through.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = 1'b0;
        if (!rst) begin
            case ({bus.r1_valid, bus.r0_valid})
                2'b01: begin
                    gnt_vld = 1'b1;
                    gnt_id  = 1'b0;
                end
                2'b10: begin
                    gnt_vld = 1'b1;
                    gnt_id  = 1'b1;
                end
                2'b11: begin
                    gnt_vld = 1'b1;
                    gnt_id  = burst_full ? ~last_gnt : last_gnt;
                end
                default: begin
                    gnt_vld = 1'b0;
                    gnt_id  = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        bus.r0_ready    = gnt_vld & ~gnt_id;
        bus.r1_ready    = gnt_vld &  gnt_id;
        gnt_we          = 1'b0;
        bus.mem_addr    = '0;
        bus.mem_wr_data = '0;
        bus.mem_byte_en = '0;
        bus.mem_wr_en   = 1'b0;
        if (gnt_vld) begin
            gnt_we          = gnt_id ? bus.r1_we    : bus.r0_we;
            bus.mem_addr    = gnt_id ? bus.r1_addr  : bus.r0_addr;
            bus.mem_wr_data = gnt_id ? bus.r1_wdata : bus.r0_wdata;
            bus.mem_wr_en   = gnt_we;
            if (gnt_we) begin
                bus.mem_byte_en = gnt_id ? bus.r1_be : bus.r0_be;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt   <= 1'b0;
            burst_cnt  <= '0;
            pend_valid <= 1'b0;
            pend_id    <= 1'b0;
        end else begin
            if (gnt_vld) begin
                if (gnt_id == last_gnt) begin
                    if (!burst_full) begin
                        burst_cnt <= burst_cnt + CNT_ONE;
                    end
                end else begin
                    burst_cnt <= CNT_ONE;
                    last_gnt  <= gnt_id;
                end
            end
            pend_valid <= gnt_vld & ~gnt_we;
            pend_id    <= gnt_id;
        end
    end

    // A load accepted just before reset is dropped: rvalid is masked while rst is high.
    always_comb begin
        bus.r0_rvalid = pend_valid & ~rst & ~pend_id;
        bus.r1_rvalid = pend_valid & ~rst &  pend_id;
        bus.r0_rdata  = bus.r0_rvalid ? bus.mem_rd_data : '0;
        bus.r1_rdata  = bus.r1_rvalid ? bus.mem_rd_data : '0;
    end
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed vector bench for dmem_port_arbiter with a behavioural 1-cycle-latency memory per instance.
module tb_dmem_port_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        mem_init;
    logic        pre_we;
    logic [7:0]  pre_idx;
    logic [31:0] pre_dat;

    int n_vec = 0;
    int n_bad = 0;

    dmem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_a ();
    dmem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_b ();

    dmem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(4)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a.slave));
    dmem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(1)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b.slave));

    logic [31:0] mem_a [256];
    logic [31:0] mem_b [256];

    // Memory reads old data during a write; write lands at the edge.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) begin
                mem_a[i] <= 32'hC0DE0000 | 32'(i);
                mem_b[i] <= 32'hC0DE0000 | 32'(i);
            end
        end else begin
            if (pre_we) begin
                mem_a[pre_idx] <= pre_dat;
            end else if (bus_a.mem_wr_en) begin
                for (int b = 0; b < 4; b++)
                    if (bus_a.mem_byte_en[b])
                        mem_a[bus_a.mem_addr[9:2]][8*b +: 8] <= bus_a.mem_wr_data[8*b +: 8];
            end
            if (bus_b.mem_wr_en) begin
                for (int b = 0; b < 4; b++)
                    if (bus_b.mem_byte_en[b])
                        mem_b[bus_b.mem_addr[9:2]][8*b +: 8] <= bus_b.mem_wr_data[8*b +: 8];
            end
        end
        bus_a.mem_rd_data <= mem_a[bus_a.mem_addr[9:2]];
        bus_b.mem_rd_data <= mem_b[bus_b.mem_addr[9:2]];
    end

    typedef struct packed {
        logic        v;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } req_t;

    typedef struct {
        logic        rst;
        req_t        q0;
        req_t        q1;
        logic [1:0]  rdy;
        logic        wen;
        logic [31:0] maddr;
        logic [31:0] mwd;
        logic [3:0]  mbe;
        logic [1:0]  rv;
        logic [31:0] rd0;
        logic [31:0] rd1;
    } vec_t;

    function automatic req_t NO();
        req_t r;
        r = '0;
        return r;
    endfunction

    // Loads carry be = 4'hF so the arbiter's forcing of byte enables to 0 is visible.
    function automatic req_t LD(input logic [31:0] a);
        req_t r;
        r = '0;
        r.v = 1'b1; r.addr = a; r.be = 4'hF;
        return r;
    endfunction

    function automatic req_t ST(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        req_t r;
        r.v = 1'b1; r.we = 1'b1; r.addr = a; r.wdata = d; r.be = be;
        return r;
    endfunction

    function automatic vec_t V(input logic r, input req_t q0, input req_t q1, input logic [1:0] rdy,
                               input logic wen, input logic [31:0] maddr, input logic [31:0] mwd,
                               input logic [3:0] mbe, input logic [1:0] rv,
                               input logic [31:0] rd0, input logic [31:0] rd1);
        vec_t t;
        t.rst = r; t.q0 = q0; t.q1 = q1; t.rdy = rdy; t.wen = wen; t.maddr = maddr;
        t.mwd = mwd; t.mbe = mbe; t.rv = rv; t.rd0 = rd0; t.rd1 = rd1;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic drive_a(input logic r, input req_t q0, input req_t q1);
        rst            = r;
        bus_a.r0_valid = q0.v;  bus_a.r0_we = q0.we;  bus_a.r0_addr = q0.addr;
        bus_a.r0_wdata = q0.wdata; bus_a.r0_be = q0.be;
        bus_a.r1_valid = q1.v;  bus_a.r1_we = q1.we;  bus_a.r1_addr = q1.addr;
        bus_a.r1_wdata = q1.wdata; bus_a.r1_be = q1.be;
    endtask

    task automatic drive_b(input req_t q0, input req_t q1);
        bus_b.r0_valid = q0.v;  bus_b.r0_we = q0.we;  bus_b.r0_addr = q0.addr;
        bus_b.r0_wdata = q0.wdata; bus_b.r0_be = q0.be;
        bus_b.r1_valid = q1.v;  bus_b.r1_we = q1.we;  bus_b.r1_addr = q1.addr;
        bus_b.r1_wdata = q1.wdata; bus_b.r1_be = q1.be;
    endtask

    // Advance one cycle: drive just after the rising edge, sample on the falling edge.
    task automatic step_a(input logic r, input req_t q0, input req_t q1);
        @(posedge clk); #1;
        drive_a(r, q0, q1);
        @(negedge clk);
    endtask

    int seq_a [12] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};
    int seq_b [4]  = '{0, 1, 0, 1};

    initial begin
        vec_t tbl[$];
        int   prev;

        tbl.push_back(V(0, LD(32'h100), NO(),    2'b01, 0, 32'h100, 0, 0, 2'b00, 0, 0));
        tbl.push_back(V(0, NO(), NO(),           2'b00, 0, 0, 0, 0, 2'b01, 32'hDEADBEEF, 0));
        tbl.push_back(V(0, NO(), ST(32'h204, 32'h000000AA, 4'b0001),
                                                 2'b10, 1, 32'h204, 32'hAA, 4'b0001, 2'b00, 0, 0));
        tbl.push_back(V(0, NO(), LD(32'h204),    2'b10, 0, 32'h204, 0, 0, 2'b00, 0, 0));
        tbl.push_back(V(0, NO(), NO(),           2'b00, 0, 0, 0, 0, 2'b10, 0, 32'h112233AA));
        tbl.push_back(V(0, LD(32'h100), NO(),    2'b01, 0, 32'h100, 0, 0, 2'b00, 0, 0));
        tbl.push_back(V(0, ST(32'h100, 32'h55667788, 4'hF), NO(),
                                                 2'b01, 1, 32'h100, 32'h55667788, 4'hF, 2'b01, 32'hDEADBEEF, 0));
        tbl.push_back(V(0, LD(32'h100), NO(),    2'b01, 0, 32'h100, 0, 0, 2'b00, 0, 0));
        tbl.push_back(V(0, NO(), NO(),           2'b00, 0, 0, 0, 0, 2'b01, 32'h55667788, 0));
        for (int k = 0; k < 4; k++)
            tbl.push_back(V(0, NO(), NO(),       2'b00, 0, 0, 0, 0, 2'b00, 0, 0));
        // Idle preserved last_gnt=0, burst_cnt=3: one more r0 grant, then r1 takes over.
        tbl.push_back(V(0, LD(32'h100), LD(32'h204), 2'b01, 0, 32'h100, 0, 0, 2'b00, 0, 0));
        tbl.push_back(V(0, LD(32'h100), LD(32'h204), 2'b10, 0, 32'h204, 0, 0, 2'b01, 32'h55667788, 0));
        tbl.push_back(V(0, LD(32'h100), LD(32'h204), 2'b10, 0, 32'h204, 0, 0, 2'b10, 0, 32'h112233AA));
        tbl.push_back(V(1, LD(32'h100), LD(32'h204), 2'b00, 0, 0, 0, 0, 2'b00, 0, 0));

        drive_a(1'b1, NO(), NO());
        drive_b(NO(), NO());
        mem_init = 1'b1; pre_we = 1'b0; pre_idx = '0; pre_dat = '0;
        @(posedge clk); #1;
        mem_init = 1'b0; pre_we = 1'b1; pre_idx = 8'h40; pre_dat = 32'hDEADBEEF;
        @(negedge clk);
        chk("reset r0_ready", 32'(bus_a.r0_ready), 0);
        chk("reset r1_ready", 32'(bus_a.r1_ready), 0);
        chk("reset r0_rvalid", 32'(bus_a.r0_rvalid), 0);
        chk("reset r1_rvalid", 32'(bus_a.r1_rvalid), 0);
        chk("reset mem_wr_en", 32'(bus_a.mem_wr_en), 0);
        chk("reset mem_addr", bus_a.mem_addr, 0);
        chk("reset mem_wr_data", bus_a.mem_wr_data, 0);
        chk("reset mem_byte_en", 32'(bus_a.mem_byte_en), 0);
        chk("reset r0_rdata", bus_a.r0_rdata, 0);
        chk("reset r1_rdata", bus_a.r1_rdata, 0);
        @(posedge clk); #1;
        pre_idx = 8'h81; pre_dat = 32'h11223344;
        @(posedge clk); #1;
        pre_we = 1'b0;

        foreach (tbl[i]) begin
            if (i != 0) begin
                @(posedge clk); #1;
            end
            drive_a(tbl[i].rst, tbl[i].q0, tbl[i].q1);
            @(negedge clk);
            chk($sformatf("row%0d r0_ready", i), 32'(bus_a.r0_ready), 32'(tbl[i].rdy[0]));
            chk($sformatf("row%0d r1_ready", i), 32'(bus_a.r1_ready), 32'(tbl[i].rdy[1]));
            chk($sformatf("row%0d mem_wr_en", i), 32'(bus_a.mem_wr_en), 32'(tbl[i].wen));
            chk($sformatf("row%0d mem_addr", i), bus_a.mem_addr, tbl[i].maddr);
            chk($sformatf("row%0d mem_wr_data", i), bus_a.mem_wr_data, tbl[i].mwd);
            chk($sformatf("row%0d mem_byte_en", i), 32'(bus_a.mem_byte_en), 32'(tbl[i].mbe));
            chk($sformatf("row%0d r0_rvalid", i), 32'(bus_a.r0_rvalid), 32'(tbl[i].rv[0]));
            chk($sformatf("row%0d r1_rvalid", i), 32'(bus_a.r1_rvalid), 32'(tbl[i].rv[1]));
            chk($sformatf("row%0d r0_rdata", i), bus_a.r0_rdata, tbl[i].rd0);
            chk($sformatf("row%0d r1_rdata", i), bus_a.r1_rdata, tbl[i].rd1);
        end

        // Reset mid-load: r0 load accepted, then reset with stores pending on both sides.
        step_a(0, LD(32'h100), NO());
        chk("rstload accept r0_ready", 32'(bus_a.r0_ready), 1);
        for (int k = 0; k < 2; k++) begin
            step_a(1, ST(32'h100, 32'hBAD0BAD0, 4'hF), ST(32'h204, 32'hBAD1BAD1, 4'hF));
            chk($sformatf("rstload c%0d r0_rvalid", k), 32'(bus_a.r0_rvalid), 0);
            chk($sformatf("rstload c%0d mem_wr_en", k), 32'(bus_a.mem_wr_en), 0);
            chk($sformatf("rstload c%0d ready", k), 32'({bus_a.r1_ready, bus_a.r0_ready}), 0);
        end
        step_a(0, LD(32'h100), LD(32'h204));
        chk("rstload release r0_ready", 32'(bus_a.r0_ready), 1);
        chk("rstload release r1_ready", 32'(bus_a.r1_ready), 0);
        step_a(0, NO(), NO());
        chk("rstload post r0_rvalid", 32'(bus_a.r0_rvalid), 1);
        chk("rstload post r0_rdata", bus_a.r0_rdata, 32'h55667788);

        // Continuous contention from reset state, MAX_BURST = 4.
        step_a(1, NO(), NO());
        prev = -1;
        for (int k = 0; k < 13; k++) begin
            if (k < 12) step_a(0, LD(32'h100), LD(32'h204));
            else        step_a(0, NO(), NO());
            if (k < 12) begin
                chk($sformatf("cont%0d r0_ready", k), 32'(bus_a.r0_ready), 32'(seq_a[k] == 0));
                chk($sformatf("cont%0d r1_ready", k), 32'(bus_a.r1_ready), 32'(seq_a[k] == 1));
            end
            chk($sformatf("cont%0d r0_rvalid", k), 32'(bus_a.r0_rvalid), 32'(prev == 0));
            chk($sformatf("cont%0d r1_rvalid", k), 32'(bus_a.r1_rvalid), 32'(prev == 1));
            chk($sformatf("cont%0d r0_rdata", k), bus_a.r0_rdata, (prev == 0) ? 32'h55667788 : 32'h0);
            chk($sformatf("cont%0d r1_rdata", k), bus_a.r1_rdata, (prev == 1) ? 32'h112233AA : 32'h0);
            prev = (k < 12) ? seq_a[k] : -1;
        end

        // MAX_BURST = 1 instance: strict alternation with correctly routed responses.
        prev = -1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            if (k < 4) drive_b(LD(32'h010), LD(32'h020));
            else       drive_b(NO(), NO());
            @(negedge clk);
            if (k < 4) begin
                chk($sformatf("alt%0d r0_ready", k), 32'(bus_b.r0_ready), 32'(seq_b[k] == 0));
                chk($sformatf("alt%0d r1_ready", k), 32'(bus_b.r1_ready), 32'(seq_b[k] == 1));
            end
            chk($sformatf("alt%0d r0_rvalid", k), 32'(bus_b.r0_rvalid), 32'(prev == 0));
            chk($sformatf("alt%0d r1_rvalid", k), 32'(bus_b.r1_rvalid), 32'(prev == 1));
            chk($sformatf("alt%0d r0_rdata", k), bus_b.r0_rdata, (prev == 0) ? 32'hC0DE0004 : 32'h0);
            chk($sformatf("alt%0d r1_rdata", k), bus_b.r1_rdata, (prev == 1) ? 32'hC0DE0008 : 32'h0);
            prev = (k < 4) ? seq_b[k] : -1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
